gobou_layer_sched: RTL and testbench

- Sequencer in front of the gobou fully-connected engine.
- Holds a small table of per-layer descriptors: input count, output count, input base address and output base address.
- On start, it drives gobou's total_in, total_out, input_addr and output_addr for each layer in turn, pulses req and waits for ack.
- Once the last layer finishes, it pulses done. This chains multi-layer FC inference, e.g. 800->500->10, without host involvement between layers.

---
 rtl/gobou_layer_sched.sv | 204 ++++++++++++++++++++
 tb/tb_gobou_layer_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gobou_layer_sched.sv
// Layer sequencer for the gobou FC engine: walks a small descriptor table and issues one req per layer.
// Optional build macro GOBOU_SCHED_PERF_EN adds perf_cycles / perf_layer counters.
module gobou_layer_sched #(
  parameter int LWIDTH   = 10,
  parameter int IMGSIZE  = 12,
  parameter int MAXLAYER = 4,
  parameter int LAYLOG   = 2
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               cfg_we,
  input  logic [LAYLOG-1:0]  cfg_idx,
  input  logic [LWIDTH-1:0]  cfg_in,
  input  logic [LWIDTH-1:0]  cfg_out,
  input  logic [IMGSIZE-1:0] cfg_iaddr,
  input  logic [IMGSIZE-1:0] cfg_oaddr,
  input  logic [LAYLOG:0]    n_layer,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LAYLOG-1:0]  layer_idx,
  output logic               req,
  input  logic               ack,
  output logic [LWIDTH-1:0]  total_in,
  output logic [LWIDTH-1:0]  total_out,
  output logic [IMGSIZE-1:0] input_addr,
  output logic [IMGSIZE-1:0] output_addr
`ifdef GOBOU_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_layer
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [LAYLOG:0] MAX_NL  = (LAYLOG+1)'(MAXLAYER);
  localparam logic [LAYLOG:0] CNT_ONE = {{LAYLOG{1'b0}}, 1'b1};

  state_t              state_r;
  logic [LWIDTH-1:0]   tab_in_r    [MAXLAYER];
  logic [LWIDTH-1:0]   tab_out_r   [MAXLAYER];
  logic [IMGSIZE-1:0]  tab_iaddr_r [MAXLAYER];
  logic [IMGSIZE-1:0]  tab_oaddr_r [MAXLAYER];
  logic [LAYLOG:0]     nl_r;
  logic [LAYLOG:0]     cnt_r;
  logic                wait_first_r;

  logic [LAYLOG:0]     nl_s;
  logic [LAYLOG-1:0]   sel_s;
  logic [LAYLOG:0]     cnt_inc_s;
  logic                skip_s;

  // Layer-count clamp and descriptor lookup for the current counter value
  always_comb begin
    nl_s      = n_layer;
    sel_s     = cnt_r[LAYLOG-1:0];
    cnt_inc_s = cnt_r + CNT_ONE;
    skip_s    = (tab_in_r[sel_s] == {LWIDTH{1'b0}}) || (tab_out_r[sel_s] == {LWIDTH{1'b0}});
    if (n_layer > MAX_NL) begin
      nl_s = MAX_NL;
    end else begin
      nl_s = n_layer;
    end
  end

  // Descriptor table; writable only while idle so a running chain sees a frozen table
  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < MAXLAYER; i++) begin
        tab_in_r[i]    <= {LWIDTH{1'b0}};
        tab_out_r[i]   <= {LWIDTH{1'b0}};
        tab_iaddr_r[i] <= {IMGSIZE{1'b0}};
        tab_oaddr_r[i] <= {IMGSIZE{1'b0}};
      end
    end else if (cfg_we && (state_r == S_IDLE)) begin
      tab_in_r[cfg_idx]    <= cfg_in;
      tab_out_r[cfg_idx]   <= cfg_out;
      tab_iaddr_r[cfg_idx] <= cfg_iaddr;
      tab_oaddr_r[cfg_idx] <= cfg_oaddr;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (xrst) begin
      state_r      <= S_IDLE;
      nl_r         <= {(LAYLOG+1){1'b0}};
      cnt_r        <= {(LAYLOG+1){1'b0}};
      wait_first_r <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      req          <= 1'b0;
      layer_idx    <= {LAYLOG{1'b0}};
      total_in     <= {LWIDTH{1'b0}};
      total_out    <= {LWIDTH{1'b0}};
      input_addr   <= {IMGSIZE{1'b0}};
      output_addr  <= {IMGSIZE{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          req  <= 1'b0;
          done <= 1'b0;
          if (start) begin
            nl_r  <= nl_s;
            cnt_r <= {(LAYLOG+1){1'b0}};
            busy  <= 1'b1;
            state_r <= (nl_s == {(LAYLOG+1){1'b0}}) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          total_in    <= tab_in_r[sel_s];
          total_out   <= tab_out_r[sel_s];
          input_addr  <= tab_iaddr_r[sel_s];
          output_addr <= tab_oaddr_r[sel_s];
          layer_idx   <= sel_s;
          if (skip_s) begin
            state_r <= S_NEXT;
          end else begin
            req     <= 1'b1;
            state_r <= S_REQ;
          end
        end
        S_REQ: begin
          req          <= 1'b0;
          wait_first_r <= 1'b1;
          state_r      <= S_WAIT;
        end
        S_WAIT: begin
          // first wait cycle masks an ack still high from the previous layer
          if (wait_first_r) begin
            wait_first_r <= 1'b0;
          end else if (ack) begin
            state_r <= S_NEXT;
          end
        end
        S_NEXT: begin
          cnt_r <= cnt_inc_s;
          if (cnt_inc_s == nl_r) begin
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            state_r <= S_LOAD;
          end
        end
        S_DONE: begin
          // done is already up when arriving from S_NEXT; the zero-layer path raises it here
          done    <= ~done;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          req     <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GOBOU_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  logic [31:0] lat_r;

  // Run-length and per-layer req-to-ack latency counters, saturating
  always_ff @(posedge clk) begin
    if (xrst) begin
      perf_cycles <= 32'd0;
      perf_layer  <= 32'd0;
      lat_r       <= 32'd0;
    end else if ((state_r == S_IDLE) && start) begin
      perf_cycles <= 32'd0;
      perf_layer  <= 32'd0;
      lat_r       <= 32'd0;
    end else begin
      if (busy) begin
        perf_cycles <= sat_inc(perf_cycles);
      end
      case (state_r)
        S_REQ: lat_r <= 32'd1;
        S_WAIT: begin
          lat_r <= sat_inc(lat_r);
          if (!wait_first_r && ack) begin
            perf_layer <= lat_r;
          end
        end
        default: lat_r <= lat_r;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gobou_layer_sched.sv
// Scoreboard bench for gobou_layer_sched: expected req/done events are queued by the stimulus and checked by a monitor.
module tb_gobou_layer_sched;
  localparam int LW = 10;
  localparam int IS = 12;
  localparam int ML = 4;
  localparam int LL = 2;

  logic          clk = 1'b0;
  logic          xrst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [LL-1:0] cfg_idx = '0;
  logic [LW-1:0] cfg_in = '0;
  logic [LW-1:0] cfg_out = '0;
  logic [IS-1:0] cfg_iaddr = '0;
  logic [IS-1:0] cfg_oaddr = '0;
  logic [LL:0]   n_layer = '0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic          busy, done, req;
  logic [LL-1:0] layer_idx;
  logic [LW-1:0] total_in, total_out;
  logic [IS-1:0] input_addr, output_addr;
`ifdef GOBOU_SCHED_PERF_EN
  logic [31:0]   perf_cycles, perf_layer;
`endif

  gobou_layer_sched #(.LWIDTH(LW), .IMGSIZE(IS), .MAXLAYER(ML), .LAYLOG(LL)) dut (
    .clk(clk), .xrst(xrst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_in(cfg_in),
    .cfg_out(cfg_out), .cfg_iaddr(cfg_iaddr), .cfg_oaddr(cfg_oaddr), .n_layer(n_layer),
    .start(start), .busy(busy), .done(done), .layer_idx(layer_idx), .req(req), .ack(ack),
    .total_in(total_in), .total_out(total_out), .input_addr(input_addr), .output_addr(output_addr)
`ifdef GOBOU_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_layer(perf_layer)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int ack_delay = 50;
  int ack_hold = 1;
  int win_q[$];

  typedef struct {
    bit is_done;
    int cyc;
    int lidx;
    int tin;
    int tout;
    int ia;
    int oa;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  bit   mon_ok;

  int m_in[ML], m_out[ML], m_ia[ML], m_oa[ML];

  // monitor: every req or done pulse pops one expected event
  always @(negedge clk) begin
    if (!xrst && (req || done)) begin
      if (req) req_cnt++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got req=%0d done=%0d at cycle %0d, expected no event", req, done, cyc);
      end else begin
        mon_e = sb.pop_front();
        mon_ok = (done == mon_e.is_done) && (req == !mon_e.is_done) && (cyc == mon_e.cyc);
        if (!mon_e.is_done)
          mon_ok = mon_ok && (int'(layer_idx) == mon_e.lidx) && (int'(total_in) == mon_e.tin) &&
                   (int'(total_out) == mon_e.tout) && (int'(input_addr) == mon_e.ia) &&
                   (int'(output_addr) == mon_e.oa);
        if (!mon_ok) begin
          n_fail++;
          $display("FAIL %s: got cyc=%0d req=%0d done=%0d idx=%0d in=%0d out=%0d ia=%0d oa=%0d, expected cyc=%0d idx=%0d in=%0d out=%0d ia=%0d oa=%0d",
                   mon_e.is_done ? "done_event" : "req_event", cyc, req, done, layer_idx, total_in,
                   total_out, input_addr, output_addr, mon_e.cyc, mon_e.lidx, mon_e.tin, mon_e.tout,
                   mon_e.ia, mon_e.oa);
        end
      end
    end
  end

  // gobou model: ack rises ack_delay cycles after each req and stays for ack_hold cycles
  always @(negedge clk) if (!xrst && req) win_q.push_back(cyc + ack_delay);

  initial forever begin
    @(posedge clk);
    #1;
    ack = 1'b0;
    while (win_q.size() > 0 && (win_q[0] + ack_hold - 1) < cyc) void'(win_q.pop_front());
    foreach (win_q[i]) if (win_q[i] <= cyc && cyc <= win_q[i] + ack_hold - 1) ack = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cfg_drive(input int idx, input int i, input int o, input int ia, input int oa, input bit upd);
    cfg_we = 1'b1;
    cfg_idx = LL'(idx);
    cfg_in = LW'(i);
    cfg_out = LW'(o);
    cfg_iaddr = IS'(ia);
    cfg_oaddr = IS'(oa);
    if (upd) begin
      m_in[idx] = i; m_out[idx] = o; m_ia[idx] = ia; m_oa[idx] = oa;
    end
  endtask

  task automatic cfg(input int idx, input int i, input int o, input int ia, input int oa, input bit upd);
    cfg_drive(idx, i, o, ia, oa, upd);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic push_req(input int c, input int k);
    sb.push_back('{is_done: 1'b0, cyc: c, lidx: k, tin: m_in[k], tout: m_out[k], ia: m_ia[k], oa: m_oa[k]});
  endtask

  task automatic push_done(input int c);
    sb.push_back('{is_done: 1'b1, cyc: c, lidx: 0, tin: 0, tout: 0, ia: 0, oa: 0});
  endtask

  task automatic pulse_start(input int nl);
    start = 1'b1;
    n_layer = (LL+1)'(nl);
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) tick(1);
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  int s;
  int base;

  initial begin
    for (int k = 0; k < ML; k++) begin
      m_in[k] = 0; m_out[k] = 0; m_ia[k] = 0; m_oa[k] = 0;
    end
    // reset and idle
    tick(2);
    chk("reset_ctrl", int'({busy, done, req, layer_idx}), 0);
    chk("reset_counts", int'(total_in) + int'(total_out), 0);
    chk("reset_addrs", int'(input_addr) + int'(output_addr), 0);
    xrst = 1'b0;
    tick(100);
    chk("idle_no_req", req_cnt, 0);

    // two-layer chain, with a start issued while busy
    cfg(0, 800, 500, 0, 1000, 1'b1);
    cfg(1, 500, 10, 1000, 2000, 1'b1);
    ack_delay = 50; ack_hold = 1;
    base = req_cnt; s = cyc;
    push_req(s + 2, 0); push_req(s + 55, 1); push_done(s + 107);
    pulse_start(2);
    tick(4);
    pulse_start(1);
    drain("chain_drain", 200);
    chk("chain_req_count", req_cnt - base, 2);
    tick(2);
    chk("chain_busy_after", int'(busy), 0);

    // stale ack held through the first wait cycle of layer 1
    ack_delay = 10; ack_hold = 5;
    s = cyc;
    push_req(s + 2, 0); push_req(s + 15, 1); push_done(s + 27);
    pulse_start(2);
    drain("stale_drain", 100);
    tick(10);

    // skipped entry with cfg_out=0
    cfg(0, 100, 20, 5, 6, 1'b1);
    cfg(1, 30, 0, 7, 8, 1'b1);
    cfg(2, 40, 3, 9, 10, 1'b1);
    cfg(3, 60, 70, 11, 12, 1'b1);
    ack_delay = 5; ack_hold = 1;
    base = req_cnt; s = cyc;
    push_req(s + 2, 0); push_req(s + 12, 2); push_done(s + 19);
    pulse_start(3);
    tick(9);
    chk("skip_layer_idx1", int'(layer_idx), 1);
    drain("skip_drain", 60);
    chk("skip_req_count", req_cnt - base, 2);

    // n_layer=7 clamps to four layers
    cfg(1, 30, 40, 7, 8, 1'b1);
    ack_delay = 3;
    base = req_cnt; s = cyc;
    for (int k = 0; k < ML; k++) push_req(s + 2 + 6 * k, k);
    push_done(s + 25);
    pulse_start(7);
    drain("clamp_drain", 60);
    chk("clamp_req_count", req_cnt - base, 4);

    // zero layers
    base = req_cnt; s = cyc;
    push_done(s + 2);
    pulse_start(0);
    chk("zero_busy_c1", int'(busy), 1);
    tick(1);
    chk("zero_busy_c2", int'(busy), 0);
    drain("zero_drain", 10);
    chk("zero_req_count", req_cnt - base, 0);

    // start and cfg_we in the same idle cycle
    ack_delay = 2;
    s = cyc;
    cfg_drive(0, 21, 22, 23, 24, 1'b1);
    push_req(s + 2, 0); push_done(s + 6);
    pulse_start(1);
    cfg_we = 1'b0;
    drain("same_cycle_cfg_drain", 20);

    // write attempted while busy is dropped
    s = cyc;
    push_req(s + 2, 0); push_done(s + 6);
    pulse_start(1);
    cfg(0, 99, 98, 97, 96, 1'b0);
    drain("lock_run1", 20);
    s = cyc;
    push_req(s + 2, 0); push_done(s + 6);
    pulse_start(1);
    drain("lock_run2", 20);

    // reset during S_WAIT aborts and clears the table
    ack_delay = 50;
    s = cyc;
    push_req(s + 2, 0);
    pulse_start(2);
    tick(9);
    xrst = 1'b1;
    tick(1);
    chk("abort_req", int'(req), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_total_in", int'(total_in), 0);
    for (int k = 0; k < ML; k++) begin
      m_in[k] = 0; m_out[k] = 0; m_ia[k] = 0; m_oa[k] = 0;
    end
    xrst = 1'b0;
    tick(60);
    chk("abort_no_late_event", sb.size(), 0);
    base = req_cnt; s = cyc;
    push_done(s + 3);
    pulse_start(1);
    drain("abort_cleared_drain", 20);
    chk("abort_cleared_no_req", req_cnt - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
